// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared widths, reset PC and the fetch packet type used by the
//            instruction-fetch stage and its output buffer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int INST_W      = 32;
  localparam int IMEM_ADDR_W = 10;
  localparam int RESET_PC    = 0;

  // One decoded-stage item: word address (zero-extended) and instruction.
  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_pkt_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small circular buffer of fetch packets between the memory read
//            stage and decode. Head is presented combinationally.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            i_push/i_data - write one packet
//            i_pop        - drop the head packet
//            i_clear      - discard all contents (priority over push/pop)
//            o_head       - head packet, all-zero while empty
//            o_count      - number of stored packets
//            o_full/o_empty - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_clear,
  input  fetch_pkt_t                   i_data,
  output fetch_pkt_t                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_PTR_W = $clog2(DEPTH);

  fetch_pkt_t               r_mem [DEPTH];
  logic [c_PTR_W-1:0]       r_rd_ptr;
  logic [c_PTR_W-1:0]       r_wr_ptr;
  logic [c_CNT_W-1:0]       r_count;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch stage in front of a synchronous-read
//            instruction memory. Issues word addresses, absorbs the one-cycle
//            read latency and hands {pc, inst} to decode via valid/ready.
//            A redirect squashes everything in flight and restarts fetch.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            o_imem_addr        - word address to the memory read port
//            i_imem_data        - memory data for last cycle's address
//            i_redirect_valid   - flush and restart at i_redirect_pc
//            i_redirect_pc      - new word address (low ADDR_W bits used)
//            o_out_valid        - o_out_inst/o_out_pc hold an item
//            i_out_ready        - consumer takes the item this cycle
//            o_out_inst/o_out_pc- instruction and its word address
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch
  import mips_pkg::*;
#(
  parameter int ADDR_W    = mips_pkg::IMEM_ADDR_W,
  parameter int RESET_PC  = mips_pkg::RESET_PC,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       o_imem_addr,
  input  logic [INST_W-1:0] i_imem_data,
  input  logic              i_redirect_valid,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [INST_W-1:0] o_out_inst,
  output logic [31:0]       o_out_pc
);

  localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int c_OCC_W = c_CNT_W + 1;

  logic [ADDR_W-1:0]   r_issue_pc;
  logic [ADDR_W-1:0]   r_s2_pc;
  logic                r_s2_valid;

  logic [c_CNT_W-1:0]  w_count;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_fire;
  logic [c_OCC_W-1:0]  w_demand;
  logic [c_OCC_W-1:0]  w_room;
  fetch_pkt_t          w_push_pkt;
  fetch_pkt_t          w_head;
  logic                w_unused;

  assign w_pop = o_out_valid & i_out_ready;

  // Only issue a read if its data is guaranteed a slot when it returns:
  // stored items + the read in flight + this new one, less this cycle's pop.
  assign w_demand = c_OCC_W'(w_count) + c_OCC_W'(r_s2_valid) + c_OCC_W'(1);
  assign w_room   = c_OCC_W'(BUF_DEPTH) + c_OCC_W'(w_pop);
  assign w_fire   = !i_redirect_valid && (w_demand <= w_room);

  assign w_push          = r_s2_valid & !i_redirect_valid;
  assign w_push_pkt.pc   = 32'(r_s2_pc);
  assign w_push_pkt.inst = i_imem_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_pc <= ADDR_W'(RESET_PC);
      r_s2_pc    <= '0;
      r_s2_valid <= 1'b0;
    end else if (i_redirect_valid) begin
      r_issue_pc <= i_redirect_pc[ADDR_W-1:0];
      r_s2_valid <= 1'b0;
    end else if (w_fire) begin
      r_issue_pc <= r_issue_pc + ADDR_W'(1);
      r_s2_pc    <= r_issue_pc;
      r_s2_valid <= 1'b1;
    end else begin
      // Address holds; the memory simply re-reads it and the data is ignored.
      r_s2_valid <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (i_redirect_valid),
    .i_data  (w_push_pkt),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_imem_addr = 32'(r_issue_pc);
  assign o_out_valid = !w_fifo_empty;
  assign o_out_inst  = w_head.inst;
  assign o_out_pc    = w_head.pc;

  // The fire rule guarantees a returning read always has room.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (rst) !(w_push && w_fifo_full)
  );

  assign w_unused = ^i_redirect_pc[31:ADDR_W];

endmodule : inst_fetch
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly upstream of `inst_memory`. It generates word addresses into the memory's synchronous read port and absorbs the memory's one-cycle read latency. It delivers `{pc, instruction}` pairs to decode over a valid/ready handshake, and supports redirect (jump/branch) with squash of in-flight fetches.

## Interface
- `ADDR_W`, 10: word-address bits; `inst_memory` depth is 2^ADDR_W.
- `RESET_PC`, 0: word address of the first fetch after reset.
- `BUF_DEPTH`, 2: output buffer entries. Minimum 2, which is required for 1 instr/cycle.

- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_addr`  out  32  word address to `inst_memory.read_address`. Bits [31:ADDR_W] are always 0.
- `imem_data`  in  32  `inst_memory.data_out`. Holds the word for the address presented in the previous cycle.
- `redirect_valid`  in  1  flush and restart the fetch stream.
- `redirect_pc`  in  32  new word address. Only bits [ADDR_W-1:0] are used.
- `out_valid`  out  1  `out_inst`/`out_pc` are valid.
- `out_ready`  in  1  the consumer accepts the item this cycle.
- `out_inst`  out  32  instruction word.
- `out_pc`  out  32  word address of `out_inst`, zero-extended.

## Operation
- **Registers:**
  - `issue_pc`: drives `imem_addr` directly.
  - `s2_valid`/`s2_pc`: the read launched last cycle.
  - FIFO: `BUF_DEPTH` entries of `{pc, inst}`.
- **Handshakes:**
  - pop = `out_valid & out_ready`.
  - fire = `!redirect_valid & (count + s2_valid + 1 - pop <= BUF_DEPTH)`.
  - On fire: `issue_pc <= issue_pc + 1` (wraps modulo 2^ADDR_W), `s2_valid <= 1`, `s2_pc <= issue_pc`.
  - No fire: `issue_pc` holds, `s2_valid <= 0`. The memory re-reads the held address harmlessly.
- **Push:** if `s2_valid & !redirect_valid`, push `{s2_pc, imem_data}`. By construction a push never targets a full FIFO; a push into a full FIFO is a design error and is flagged by an assertion.
- **Output:** `out_valid` = FIFO non-empty; `out_inst`/`out_pc` = FIFO head.
- **Redirect:** redirect in cycle N has priority over fire and push.
  - A pop in cycle N still completes; the consumer owns that item.
  - At the edge: FIFO cleared, `s2_valid <= 0`, `issue_pc <= redirect_pc[ADDR_W-1:0]`.
  - Back-to-back redirects: the last one wins.
- **Width rules:** `issue_pc`/`s2_pc` are ADDR_W bits, zero-extended to 32 on `imem_addr`/`out_pc`. No byte addressing; PC + 1 is the next instruction.
- **Out of scope:** this block never drives the `inst_memory` write port.

## Timing
- **While `rst` is high:**
  - `issue_pc` = RESET_PC, `s2_valid` = 0, FIFO empty.
  - `out_valid` = 0, `out_inst` = 0, `out_pc` = 0, `imem_addr` = RESET_PC.
  - Reset asserted mid-stream clears everything immediately (asynchronous).
- **Start-up:** with C0 = first cycle `rst` is low:
  - C0: fire at RESET_PC.
  - C1: push.
  - C2: `out_valid` = 1, `out_pc` = RESET_PC.
- **Steady state:** with `out_ready` held high, 1 instruction/cycle with consecutive PCs.
- **Redirect latency:** redirect in cycle N produces, in order:
  - N+1: fire at target.
  - N+2: push.
  - N+3: `out_valid` with `out_pc` = target.
  - `out_valid` is 0 in N+1 and N+2 unless another redirect intervenes.
- **Backpressure:**
  - With `out_ready` low, the FIFO fills to BUF_DEPTH and fire stops.
  - No instruction is dropped or duplicated.
  - `out_inst`/`out_pc` are stable while `out_valid & !out_ready`.
  - When `out_ready` rises, throughput returns to 1/cycle with no bubble after the first pop.
- **Wrap:** `issue_pc` = 2^ADDR_W-1 is followed by 0. With ADDR_W=10, `out_pc` goes 1023 then 0.

## Structure
- Shared package `mips_pkg`:
  - `INST_W` = 32.
  - `IMEM_ADDR_W` = 10, the default for ADDR_W.
  - `RESET_PC`.
  - typedef `fetch_pkt_t` = `{pc[31:0], inst[31:0]}`.
- One sub-module, `fetch_fifo`:
  - Parameterised by depth.
  - Ports: push, pop, clear, count, head, full/empty.
  - Asynchronous active-high reset.
- Top level `inst_fetch` holds the PC/issue logic and instantiates `fetch_fifo`. The bench pairs it with a real `inst_memory`.

## Test plan
- **Reset stream:** memory words k = 0x1000+k, release `rst`, `out_ready` = 1. Expect `out_valid` first in C2, then `out_pc` 0,1,2,3… with `out_inst` 0x1000,0x1001,… at 1/cycle.
- **Backpressure:** drop `out_ready` for 5 cycles after PC 3 is presented. Expect PC 3 held stable, the FIFO fills to 2, and then 4,5,… resume with no gap, loss or duplicate.
- **Redirect mid-stream:** redirect to 5 when `out_pc` = 1 is accepted. Expect PCs 2–3 squashed and `out_valid` low for 2 cycles. Then `out_pc` = 5 appears 3 cycles after the redirect, followed by 6.
- **Redirect while stalled and full:** `out_ready` = 0, FIFO full, redirect to 0x200. Expect the FIFO flushed and the next item `out_pc` = 0x200. Redirect to 0x40A is truncated to 0x00A.
- **Wrap:** redirect to 1022 gives the sequence 1022, 1023, 0, 1 with `imem_addr[31:10]` = 0 throughout.
- **Mid-stream reset:** assert `rst` asynchronously mid-cycle while the FIFO is full. Expect `out_valid` = 0 and `out_pc` = 0 immediately. Restart from RESET_PC with C2 latency.
